dds_func_gen: RTL and testbench
===============================

# dds_func_gen

Multi-channel, phase-accumulator (DDS) function generator; successor to the single-channel counter-based generator. Each of NCH channels runs an independent PHASE_W-bit accumulator and produces sine (external LUT), triangle, square, PWM or sawtooth samples. Configuration is written through a valid/ready port into per-channel shadow registers and applied phase-continuously at the next period boundary. Sits between the register/AXI-lite front end and the DAC/output serialiser.

## Interface
- NCH, 2: number of independent channels (1..8)
- PHASE_W, 32: phase accumulator width
- DATA_W, 8: sample width; also PWM duty width
- LUT_AW, 8: sine LUT address width (LUT_AW <= PHASE_W)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- enable  in  NCH  per-channel run enable
- cfg_valid  in  1  config write request
- cfg_ready  out  1  config write can be accepted
- cfg_ch  in  3  target channel
- cfg_mode  in  3  wave_mode_t
- cfg_step  in  PHASE_W  phase increment per clk
- cfg_duty  in  DATA_W  PWM high threshold
- cfg_err  out  1  one-cycle pulse: write rejected
- lut_addr  out  NCH*LUT_AW  per-channel sine LUT address, channel i at [i*LUT_AW +: LUT_AW]
- lut_data  in  NCH*DATA_W  LUT read data, valid 1 clk after lut_addr
- wave_out  out  NCH*DATA_W  registered samples
- period_tick  out  NCH  one-cycle pulse on accumulator wrap

## Operation
- Per channel: active {mode, step, duty}, shadow copy, pending flag, phase register.
- Enabled: phase <= phase + step each clk, modulo 2^PHASE_W; carry-out raises period_tick. step = 0 holds phase, no tick.
- Disabled: phase held, no tick; wave_out keeps tracking the held phase.
- Sample from top bits of phase (P = phase[PHASE_W-1 -: DATA_W+1], MAX = all ones):
  - SINE: lut_addr = phase[PHASE_W-1 -: LUT_AW]; sample = lut_data
  - TRIANGLE: P[DATA_W] ? ~P[DATA_W-1:0] : P[DATA_W-1:0]
  - SQUARE: P[DATA_W] ? 0 : MAX
  - PWM: (P[DATA_W:1] < duty) ? MAX : 0; duty = 0 -> always 0
  - SAW: P[DATA_W:1]
- Config write: handshake when cfg_valid && cfg_ready.
  - cfg_ch >= NCH or cfg_mode > 4: write dropped; cfg_err pulses the next cycle; no state changes.
  - Otherwise: fields go to the shadow copy and pending[cfg_ch] is set.
- cfg_ready = !pending[cfg_ch]. This is combinational on cfg_ch.
- Apply: shadow copied to active, pending cleared. This happens in the cycle after the first period_tick that follows acceptance. If the channel is disabled, it happens in the cycle after acceptance.
- Apply never resets phase; the waveform stays phase-continuous.
- A write accepted in the same cycle as that channel's period_tick waits for the next tick.
- Reset: phase 0, active mode SINE, step 0, duty 2^(DATA_W-1), pending 0, wave_out 0, period_tick 0, cfg_err 0. cfg_ready is therefore 1.
- Reset mid-period or with a pending write discards the shadow.

## Timing
- Pipeline per channel:
  - Stage 0: phase register; lut_addr is driven combinationally from it.
  - Stage 1: lut_data and the computed samples are registered together, so all modes are aligned.
  - Stage 2: wave_out register.
- wave_out reflects the phase held 2 clks earlier in every mode. Mode changes are glitch-free at that boundary.
- period_tick is asserted in the cycle the wrapped phase value is registered.
- Config fields take effect in the phase update of the cycle after the apply cycle.
- Channels are fully independent; simultaneous ticks on all channels are legal.

## Structure
- Package func_gen_pkg:
  - wave_mode_t enum: SINE=0, TRIANGLE=1, SQUARE=2, PWM=3, SAW=4
  - MODE_MAX = 4
  - default duty constant
  - shared by the register front end.
- Sub-module dds_channel: accumulator, shadow/active registers, sample pipeline for one channel. Generated NCH times.
- Top level: cfg decode/validation, cfg_ready mux, cfg_err, port packing.

## Test plan
All cases use NCH=2, PHASE_W=32, DATA_W=8, LUT_AW=8.
1. Reset held 3 clks, then release with enable=0 -> wave_out=0, period_tick=0, cfg_ready=1, cfg_err=0.
2. ch0 SAW, step=2^24, enable[0]=1 -> wave_out[7:0] increments by 1 per clk starting 2 clks after the first phase update; period_tick[0] every 256 clks; ch1 unaffected.
3. ch1 SQUARE, step=2^30 -> wave_out[15:8] repeats 255,255,0,0; period_tick[1] every 4 clks.
4. ch0 PWM, duty=64, step=2^24 -> 64 clks of 255, then 192 clks of 0, per 256-clk period. duty=0 -> constant 0.
5. ch0 running with step=2^24; write step=2^25 at period cycle 100:
   - cfg_ready low for cfg_ch=0 until the apply cycle; a second write to ch0 is stalled.
   - The old rate continues until the tick, then the sample rate doubles with no phase jump.
   - A write to ch1 in the same window is accepted.
6. Write cfg_mode=6, then cfg_ch=3 -> cfg_err pulses once for each, the active config is unchanged. SINE with a LUT model -> wave_out equals LUT[phase[31:24]] delayed 2 clks.

Source files
------------

// File: rtl/dds_func_gen_pkg.sv
// ---------------------------------------------------------------------------
// func_gen_pkg
// Shared definitions for the DDS function generator and its register front
// end: waveform mode encoding, the highest legal mode value, the width of the
// channel-select field and the reset duty value helper.
// ---------------------------------------------------------------------------
package func_gen_pkg;

  typedef enum logic [2:0] {
    SINE     = 3'd0,
    TRIANGLE = 3'd1,
    SQUARE   = 3'd2,
    PWM      = 3'd3,
    SAW      = 3'd4
  } wave_mode_t;

  localparam logic [2:0] MODE_MAX = 3'd4;
  localparam int unsigned CH_W = 3;

  // Reset duty is half scale for any sample width (2^(w-1)).
  function automatic int unsigned defaultDuty(input int unsigned dataW);
    return 32'd1 << (dataW - 1);
  endfunction

endpackage

// File: rtl/dds_func_gen_if.sv
// ---------------------------------------------------------------------------
// dds_func_gen_if
// Configuration write port of the DDS function generator.
//   cfg_valid / cfg_ready : write handshake (master -> slave / slave -> master)
//   cfg_ch                : target channel
//   cfg_mode              : waveform mode (raw, so illegal codes can be seen)
//   cfg_step              : phase increment per clock
//   cfg_duty              : PWM high threshold
//   cfg_err               : one-cycle pulse, previous write was rejected
// ---------------------------------------------------------------------------
interface dds_func_gen_if #(
  parameter int PHASE_W = 32,
  parameter int DATA_W  = 8
);
  import func_gen_pkg::*;

  logic               cfg_valid;
  logic               cfg_ready;
  logic [CH_W-1:0]    cfg_ch;
  logic [2:0]         cfg_mode;
  logic [PHASE_W-1:0] cfg_step;
  logic [DATA_W-1:0]  cfg_duty;
  logic               cfg_err;

  modport master (
    output cfg_valid, cfg_ch, cfg_mode, cfg_step, cfg_duty,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_mode, cfg_step, cfg_duty,
    output cfg_ready, cfg_err
  );

endinterface

// File: rtl/dds_func_gen_channel.sv
// ---------------------------------------------------------------------------
// dds_channel
// One DDS channel: phase accumulator, shadow/active configuration and the
// two-stage sample pipeline.
//   clk, rst_n      : clock, synchronous active-low reset
//   enable_i        : run enable for the accumulator
//   wr_i            : accepted config write for this channel (load shadow)
//   mode_i/step_i/duty_i : config fields for the shadow copy
//   pending_o       : shadow holds a not-yet-applied write
//   lut_addr_o      : sine LUT address, combinational from the phase register
//   lut_data_i      : LUT read data, one clock after lut_addr_o
//   wave_o          : registered sample, reflects the phase of 2 clocks ago
//   tick_o          : one-cycle pulse in the cycle the wrapped phase is held
// ---------------------------------------------------------------------------
module dds_channel
  import func_gen_pkg::*;
#(
  parameter int PHASE_W = 32,
  parameter int DATA_W  = 8,
  parameter int LUT_AW  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable_i,
  input  logic               wr_i,
  input  wave_mode_t         mode_i,
  input  logic [PHASE_W-1:0] step_i,
  input  logic [DATA_W-1:0]  duty_i,
  output logic               pending_o,
  output logic [LUT_AW-1:0]  lut_addr_o,
  input  logic [DATA_W-1:0]  lut_data_i,
  output logic [DATA_W-1:0]  wave_o,
  output logic               tick_o
);

  localparam logic [DATA_W-1:0] DutyRst   = DATA_W'(defaultDuty(DATA_W));
  localparam logic [DATA_W-1:0] SampleMax = '1;

  wave_mode_t         mode_q, shMode_q, s1Mode_q;
  logic [PHASE_W-1:0] step_q, shStep_q;
  logic [DATA_W-1:0]  duty_q, shDuty_q;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               tick_q, tick_d;
  logic               pending_q, pending_d;
  logic               tickSeen_q, tickSeen_d;
  logic               applyNow;
  logic [PHASE_W:0]   phaseSum;
  logic [DATA_W:0]    topBits;
  logic [DATA_W-1:0]  sample;
  logic [DATA_W-1:0]  s1Sample_q;
  logic               s1Valid_q;
  logic [DATA_W-1:0]  wave_q;

  // Next-state for the accumulator and the apply bookkeeping. A write waits
  // for a wrap seen while it is already pending (tickSeen), so a write landing
  // in the tick cycle itself waits a full period. A stopped channel applies
  // straight away since its wrap might never come.
  always_comb begin
    phaseSum = {1'b0, phase_q} + {1'b0, step_q};
    phase_d  = phase_q;
    tick_d   = 1'b0;
    if (enable_i) begin
      phase_d = phaseSum[PHASE_W-1:0];
      tick_d  = phaseSum[PHASE_W];
    end
    applyNow   = pending_q && (tickSeen_q || !enable_i);
    tickSeen_d = pending_q && !applyNow && (tickSeen_q || tick_q);
    pending_d  = pending_q;
    if (wr_i) begin
      pending_d = 1'b1;
    end else if (applyNow) begin
      pending_d = 1'b0;
    end
  end

  // Phase register, wrap pulse and pending bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q    <= '0;
      tick_q     <= 1'b0;
      pending_q  <= 1'b0;
      tickSeen_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      tick_q     <= tick_d;
      pending_q  <= pending_d;
      tickSeen_q <= tickSeen_d;
    end
  end

  // Shadow and active configuration. Applying only swaps the increment and
  // waveform shape; the phase is never touched so the output stays continuous.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shMode_q <= SINE;
      shStep_q <= '0;
      shDuty_q <= DutyRst;
      mode_q   <= SINE;
      step_q   <= '0;
      duty_q   <= DutyRst;
    end else begin
      if (wr_i) begin
        shMode_q <= mode_i;
        shStep_q <= step_i;
        shDuty_q <= duty_i;
      end
      if (applyNow) begin
        mode_q <= shMode_q;
        step_q <= shStep_q;
        duty_q <= shDuty_q;
      end
    end
  end

  // Arithmetic waveforms from the top DATA_W+1 phase bits. SINE yields zero
  // here; its value arrives from the LUT one clock later.
  always_comb begin
    topBits = phase_q[PHASE_W-1 -: DATA_W+1];
    case (mode_q)
      TRIANGLE: sample = topBits[DATA_W] ? ~topBits[DATA_W-1:0] : topBits[DATA_W-1:0];
      SQUARE:   sample = topBits[DATA_W] ? '0 : SampleMax;
      PWM:      sample = (topBits[DATA_W:1] < duty_q) ? SampleMax : '0;
      SAW:      sample = topBits[DATA_W:1];
      default:  sample = '0;
    endcase
  end

  // Stage 1 holds the computed sample and the mode it was computed with, so
  // the stage-2 select picks LUT data or arithmetic sample for the same phase
  // and a mode change never mixes two phases.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1Sample_q <= '0;
      s1Mode_q   <= SINE;
      s1Valid_q  <= 1'b0;
    end else begin
      s1Sample_q <= sample;
      s1Mode_q   <= mode_q;
      s1Valid_q  <= 1'b1;
    end
  end

  // Stage 2 output register; held at zero until the pipeline has filled after
  // reset so stale LUT data never reaches the DAC.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wave_q <= '0;
    end else if (!s1Valid_q) begin
      wave_q <= '0;
    end else begin
      wave_q <= (s1Mode_q == SINE) ? lut_data_i : s1Sample_q;
    end
  end

  assign lut_addr_o = phase_q[PHASE_W-1 -: LUT_AW];
  assign wave_o     = wave_q;
  assign tick_o     = tick_q;
  assign pending_o  = pending_q;

endmodule

// File: rtl/dds_func_gen.sv
// ---------------------------------------------------------------------------
// dds_func_gen
// Multi-channel DDS function generator top level: config decode and
// validation, cfg_ready mux, cfg_err pulse and per-channel port packing.
//   clk, rst_n  : clock, synchronous active-low reset
//   enable      : per-channel run enable
//   cfg         : config write port (slave side)
//   lut_addr    : per-channel sine LUT address, channel i at [i*LUT_AW +: LUT_AW]
//   lut_data    : per-channel LUT read data, one clock after lut_addr
//   wave_out    : per-channel registered samples
//   period_tick : per-channel accumulator wrap pulse
// ---------------------------------------------------------------------------
module dds_func_gen
  import func_gen_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int PHASE_W = 32,
  parameter int DATA_W  = 8,
  parameter int LUT_AW  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NCH-1:0]        enable,
  dds_func_gen_if.slave         cfg,
  output logic [NCH*LUT_AW-1:0] lut_addr,
  input  logic [NCH*DATA_W-1:0] lut_data,
  output logic [NCH*DATA_W-1:0] wave_out,
  output logic [NCH-1:0]        period_tick
);

  logic [NCH-1:0] pending;
  logic [NCH-1:0] wrStrobe;
  logic           chInRange;
  logic           modeValid;
  logic           readyMux;
  logic           accept;
  logic           cfgErr_q, cfgErr_d;

  // Ready follows the pending flag of the addressed channel. Out-of-range
  // channels report ready so the bad write can complete and be flagged.
  always_comb begin
    readyMux = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (int'(cfg.cfg_ch) == i) begin
        readyMux = !pending[i];
      end
    end
    chInRange = int'(cfg.cfg_ch) < NCH;
    modeValid = cfg.cfg_mode <= MODE_MAX;
    accept    = cfg.cfg_valid && readyMux;
    cfgErr_d  = accept && !(chInRange && modeValid);
  end

  // Rejected writes change nothing; they only raise a one-cycle error pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfgErr_q <= 1'b0;
    end else begin
      cfgErr_q <= cfgErr_d;
    end
  end

  assign cfg.cfg_ready = readyMux;
  assign cfg.cfg_err   = cfgErr_q;

  for (genvar g = 0; g < NCH; g++) begin : gCh
    assign wrStrobe[g] = accept && chInRange && modeValid && (int'(cfg.cfg_ch) == g);

    dds_channel #(
      .PHASE_W (PHASE_W),
      .DATA_W  (DATA_W),
      .LUT_AW  (LUT_AW)
    ) uChannel (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable_i   (enable[g]),
      .wr_i       (wrStrobe[g]),
      .mode_i     (wave_mode_t'(cfg.cfg_mode)),
      .step_i     (cfg.cfg_step),
      .duty_i     (cfg.cfg_duty),
      .pending_o  (pending[g]),
      .lut_addr_o (lut_addr[g*LUT_AW +: LUT_AW]),
      .lut_data_i (lut_data[g*DATA_W +: DATA_W]),
      .wave_o     (wave_out[g*DATA_W +: DATA_W]),
      .tick_o     (period_tick[g])
    );
  end

endmodule

// File: tb/tb_dds_func_gen.sv
// ---------------------------------------------------------------------------
// tb_dds_func_gen
// Self-checking bench for dds_func_gen (NCH=2, PHASE_W=32, DATA_W=8,
// LUT_AW=8). A cycle-level reference model built from the waveform formulas
// and the apply rules predicts every output every cycle; directed sections
// cover the main scenarios and a randomized section covers the rest.
// ---------------------------------------------------------------------------
module tb_dds_func_gen;
  import func_gen_pkg::*;

  localparam int NCH     = 2;
  localparam int PHASE_W = 32;
  localparam int DATA_W  = 8;
  localparam int LUT_AW  = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  enable;
  logic [15:0] lut_addr;
  logic [15:0] lut_data;
  logic [15:0] wave_out;
  logic [1:0]  period_tick;

  dds_func_gen_if #(.PHASE_W(PHASE_W), .DATA_W(DATA_W)) cfgIf ();

  dds_func_gen #(
    .NCH     (NCH),
    .PHASE_W (PHASE_W),
    .DATA_W  (DATA_W),
    .LUT_AW  (LUT_AW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .cfg         (cfgIf),
    .lut_addr    (lut_addr),
    .lut_data    (lut_data),
    .wave_out    (wave_out),
    .period_tick (period_tick)
  );

  always #5 clk = ~clk;

  // Synchronous sine ROM shared by both channels: data one clock after address.
  logic [7:0] lutRom [256];
  logic [7:0] lutQ [2];
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) lutQ[i] <= lutRom[lut_addr[i*8 +: 8]];
  end
  assign lut_data = {lutQ[1], lutQ[0]};

  // Reference model state
  logic [31:0] mPhase [2];
  logic [31:0] mStep [2];
  logic [31:0] sStep [2];
  logic [2:0]  mMode [2];
  logic [2:0]  sMode [2];
  logic [7:0]  mDuty [2];
  logic [7:0]  sDuty [2];
  logic        mPending [2];
  logic        mTick [2];
  int          mAcceptCyc [2];
  int          mLastTick [2];
  logic        mErr;
  logic [7:0]  hist [2][4];
  int          cyc;
  logic        lastAccept;

  int errCount;
  int checkCount;
  int tickCnt [2];
  int highCnt [2];
  int errPulses;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Sample for a phase value, straight from the waveform definitions.
  function automatic logic [7:0] refSample(input logic [31:0] ph, input logic [2:0] mode,
                                           input logic [7:0] duty);
    int p9;
    int half;
    p9   = int'(ph >> 23);
    half = int'(ph >> 24);
    case (mode)
      3'd0:    return lutRom[half];
      3'd1:    return (p9 >= 256) ? 8'(511 - p9) : 8'(p9);
      3'd2:    return (p9 >= 256) ? 8'd0 : 8'd255;
      3'd3:    return (half < int'(duty)) ? 8'd255 : 8'd0;
      default: return 8'(half);
    endcase
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      mPhase[i] = '0; mStep[i] = '0; sStep[i] = '0;
      mMode[i] = 3'd0; sMode[i] = 3'd0;
      mDuty[i] = 8'd128; sDuty[i] = 8'd128;
      mPending[i] = 1'b0; mTick[i] = 1'b0;
      mAcceptCyc[i] = -10; mLastTick[i] = -10;
      for (int k = 0; k < 4; k++) hist[i][k] = '0;
    end
    mErr = 1'b0;
    cyc = 0;
  endtask

  task automatic clearCounts();
    for (int i = 0; i < 2; i++) begin
      tickCnt[i] = 0;
      highCnt[i] = 0;
    end
    errPulses = 0;
  endtask

  // One clock: compare all outputs at the falling edge, then advance the
  // model with the inputs that the rising edge will see.
  task automatic runCycle();
    logic        expReady;
    logic        acc;
    logic        cfgOk;
    logic        apply;
    logic [32:0] sum;
    int          ch;
    @(negedge clk);
    ch = int'(cfgIf.cfg_ch);
    expReady = 1'b1;
    if (ch < 2) expReady = !mPending[ch];
    checkOutput("cfg_ready", 32'(cfgIf.cfg_ready), 32'(expReady));
    checkOutput("cfg_err", 32'(cfgIf.cfg_err), 32'(mErr));
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("tick%0d", i), 32'(period_tick[i]), 32'(mTick[i]));
      checkOutput($sformatf("wave%0d", i), 32'(wave_out[i*8 +: 8]),
                  (cyc >= 2) ? 32'(hist[i][(cyc-2)%4]) : 32'd0);
      hist[i][cyc%4] = refSample(mPhase[i], mMode[i], mDuty[i]);
      tickCnt[i] += int'(period_tick[i]);
      if (wave_out[i*8 +: 8] == 8'hFF) highCnt[i]++;
    end
    errPulses += int'(cfgIf.cfg_err);
    acc = cfgIf.cfg_valid && expReady;
    lastAccept = acc;
    cfgOk = (ch < 2) && (int'(cfgIf.cfg_mode) <= 4);
    for (int i = 0; i < 2; i++) begin
      apply = mPending[i] && (!enable[i] || (mLastTick[i] == cyc - 1 && mAcceptCyc[i] < cyc - 1));
      if (mTick[i]) mLastTick[i] = cyc;
      if (enable[i]) begin
        sum = {1'b0, mPhase[i]} + {1'b0, mStep[i]};
        mPhase[i] = sum[31:0];
        mTick[i] = sum[32];
      end else begin
        mTick[i] = 1'b0;
      end
      if (apply) begin
        mMode[i] = sMode[i]; mStep[i] = sStep[i]; mDuty[i] = sDuty[i];
        mPending[i] = 1'b0;
      end
      if (acc && cfgOk && ch == i) begin
        sMode[i] = cfgIf.cfg_mode; sStep[i] = cfgIf.cfg_step; sDuty[i] = cfgIf.cfg_duty;
        mPending[i] = 1'b1;
        mAcceptCyc[i] = cyc;
      end
    end
    mErr = acc && !cfgOk;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic applyStimulus(input int n);
    repeat (n) runCycle();
  endtask

  task automatic writeCfg(input logic [2:0] ch, input logic [2:0] mode, input logic [31:0] step,
                          input logic [7:0] duty, output int waited);
    cfgIf.cfg_valid = 1'b1;
    cfgIf.cfg_ch    = ch;
    cfgIf.cfg_mode  = mode;
    cfgIf.cfg_step  = step;
    cfgIf.cfg_duty  = duty;
    waited = 0;
    runCycle();
    while (!lastAccept && waited < 1000) begin
      waited++;
      runCycle();
    end
    if (!lastAccept) checkOutput("wr_timeout", 32'd0, 32'd1);
    cfgIf.cfg_valid = 1'b0;
  endtask

  task automatic doReset(input int n);
    rst_n = 1'b0;
    enable = 2'b00;
    cfgIf.cfg_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    modelReset();
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w;
    int guard;
    errCount = 0;
    checkCount = 0;
    lastAccept = 1'b0;
    clearCounts();
    for (int i = 0; i < 256; i++) lutRom[i] = 8'($urandom);
    cfgIf.cfg_ch = '0; cfgIf.cfg_mode = '0; cfgIf.cfg_step = '0; cfgIf.cfg_duty = '0;
    modelReset();
    doReset(3);

    // Reset state
    checkOutput("rst_wave", 32'(wave_out), 32'd0);
    checkOutput("rst_tick", 32'(period_tick), 32'd0);
    checkOutput("rst_ready", 32'(cfgIf.cfg_ready), 32'd1);
    checkOutput("rst_err", 32'(cfgIf.cfg_err), 32'd0);
    applyStimulus(4);

    // ch0 sawtooth at 1 LSB per clock
    writeCfg(3'd0, SAW, 32'h0100_0000, 8'd128, w);
    applyStimulus(2);
    enable = 2'b01;
    applyStimulus(3);
    clearCounts();
    applyStimulus(512);
    checkOutput("saw_ticks0", 32'(tickCnt[0]), 32'd2);
    checkOutput("saw_ticks1", 32'(tickCnt[1]), 32'd0);

    // ch1 square at quarter rate
    writeCfg(3'd1, SQUARE, 32'h4000_0000, 8'd128, w);
    applyStimulus(2);
    enable = 2'b11;
    applyStimulus(4);
    clearCounts();
    applyStimulus(16);
    checkOutput("sq_ticks1", 32'(tickCnt[1]), 32'd4);
    checkOutput("sq_high1", 32'(highCnt[1]), 32'd8);

    // ch0 PWM duty 64, then duty 0
    writeCfg(3'd0, PWM, 32'h0100_0000, 8'd64, w);
    applyStimulus(300);
    clearCounts();
    applyStimulus(256);
    checkOutput("pwm_high", 32'(highCnt[0]), 32'd64);
    writeCfg(3'd0, PWM, 32'h0100_0000, 8'd0, w);
    applyStimulus(300);
    clearCounts();
    applyStimulus(256);
    checkOutput("pwm0_high", 32'(highCnt[0]), 32'd0);

    // Rate change at period cycle 100, stall of a second write, ch1 accepted meanwhile
    writeCfg(3'd0, SAW, 32'h0100_0000, 8'd0, w);
    applyStimulus(300);
    guard = 0;
    while (mPhase[0][31:24] != 8'd100 && guard < 600) begin
      runCycle();
      guard++;
    end
    if (guard >= 600) checkOutput("phase100_timeout", 32'd0, 32'd1);
    writeCfg(3'd0, SAW, 32'h0200_0000, 8'd0, w);
    checkOutput("rate_wr_wait", 32'(w), 32'd0);
    writeCfg(3'd1, TRIANGLE, 32'h1000_0000, 8'd0, w);
    checkOutput("ch1_wr_wait", 32'(w), 32'd0);
    writeCfg(3'd0, SAW, 32'h0200_0000, 8'd0, w);
    checkOutput("ch0_stall", 32'(w), 32'd156);
    applyStimulus(300);
    clearCounts();
    applyStimulus(256);
    checkOutput("fast_ticks0", 32'(tickCnt[0]), 32'd2);

    // Rejected writes, then sine from the LUT
    clearCounts();
    writeCfg(3'd0, 3'd6, 32'h0100_0000, 8'd1, w);
    writeCfg(3'd3, SAW, 32'h0100_0000, 8'd1, w);
    applyStimulus(2);
    checkOutput("err_pulses", 32'(errPulses), 32'd2);
    writeCfg(3'd0, SINE, 32'h0123_4567, 8'd0, w);
    applyStimulus(400);

    // Reset with a write still pending discards it
    writeCfg(3'd1, SAW, 32'h0010_0000, 8'd0, w);
    doReset(2);
    cfgIf.cfg_ch = 3'd1;
    #1;
    checkOutput("rst2_ready1", 32'(cfgIf.cfg_ready), 32'd1);
    checkOutput("rst2_wave", 32'(wave_out), 32'd0);
    applyStimulus(6);

    // Randomized traffic
    enable = 2'($urandom);
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 63) == 0) enable = 2'($urandom);
      cfgIf.cfg_valid = ($urandom_range(0, 4) == 0);
      cfgIf.cfg_ch    = 3'($urandom_range(0, 3));
      cfgIf.cfg_mode  = 3'($urandom_range(0, 6));
      case ($urandom_range(0, 3))
        0:       cfgIf.cfg_step = 32'd1 << $urandom_range(20, 30);
        1:       cfgIf.cfg_step = $urandom;
        2:       cfgIf.cfg_step = 32'd0;
        default: cfgIf.cfg_step = 32'd1 << $urandom_range(24, 31);
      endcase
      cfgIf.cfg_duty = 8'($urandom);
      runCycle();
    end
    cfgIf.cfg_valid = 1'b0;
    applyStimulus(4);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
